// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
// Request/acknowledge bundle for one requester of the shared SRAM.
//   req    requester -> arbiter   access request, held until ack
//   we     requester -> arbiter   1 = write, 0 = read
//   addr   requester -> arbiter   SRAM byte address
//   wdata  requester -> arbiter   write data
//   ack    arbiter -> requester   one-cycle completion pulse
//   rdata  arbiter -> requester   read data, valid in the ack cycle
// master: requester side. slave: arbiter side.
interface sram_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one asynchronous SRAM between the logger capture engine (L) and the
// SPI host bridge (H). One access runs at a time through
// IDLE -> SETUP -> STROBE -> RECOVER -> IDLE; all SRAM pins and requester
// outputs come straight from flops.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   l_bus      logger requester (slave side of sram_arbiter_if)
//   h_bus      host requester   (slave side of sram_arbiter_if)
//   busy       1 whenever an access is in progress
//   sram_addr  SRAM address pins
//   sram_data  SRAM data pins, driven only while a write is in progress
//   sram_cen   chip enable, active low
//   sram_oen   output enable, active low
//   sram_wen   write enable, active low
// Parameters:
//   ADDR_W, DATA_W  SRAM geometry
//   STROBE_CYC      cycles oen/wen are held low per access (>= 1)
module sram_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int STROBE_CYC = 6
) (
    input  logic              clk,
    input  logic              rst,
    sram_arbiter_if.slave     l_bus,
    sram_arbiter_if.slave     h_bus,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_cen,
    output logic              sram_oen,
    output logic              sram_wen
);

    localparam int CNT_W = (STROBE_CYC < 1) ? 1 : $clog2(STROBE_CYC + 1);
    // Counter runs STROBE_CYC-1 down to 0; zero marks the last strobe cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic              last_h_q;
    logic              port_h_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_q;
    logic              cen_q;
    logic              oen_q;
    logic              wen_q;
    logic              busy_q;
    logic              l_ack_q;
    logic              h_ack_q;
    logic [DATA_W-1:0] l_rdata_q;
    logic [DATA_W-1:0] h_rdata_q;

    logic              any_req;
    logic              grant;
    logic              grant_h;
    logic              last_strobe;

    logic              port_h_d;
    logic              we_d;
    logic              busy_d;
    logic              cen_d;
    logic              oen_d;
    logic              wen_d;
    logic              drive_d;
    logic              l_ack_d;
    logic              h_ack_d;

    // Arbitration: a lone requester wins outright; on a tie the port that
    // did not hold the previous grant wins, so neither side can starve.
    always_comb begin
        any_req     = l_bus.req | h_bus.req;
        grant       = (state_q == IDLE) && any_req;
        if (l_bus.req && h_bus.req) begin
            grant_h = ~last_h_q;
        end else begin
            grant_h = h_bus.req;
        end
        last_strobe = (state_q == STROBE) && (cnt_q == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (last_strobe) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Values are computed from the state being entered so that
    // the registered pins line up with that state's cycle.
    always_comb begin
        port_h_d = grant ? grant_h : port_h_q;
        we_d     = grant ? (grant_h ? h_bus.we : l_bus.we) : we_q;
        busy_d   = (state_d != IDLE);
        cen_d    = ~busy_d;
        oen_d    = ~((state_d == STROBE) && !we_d);
        wen_d    = ~((state_d == STROBE) && we_d);
        // Write data is put on the bus one cycle before wen falls and held one
        // cycle after it rises; reads never drive, so oen=0 never meets a driver.
        drive_d  = busy_d && we_d;
        l_ack_d  = (state_d == RECOVER) && !port_h_d;
        h_ack_d  = (state_d == RECOVER) && port_h_d;
    end

    // Registered outputs, latched request and strobe counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            last_h_q  <= 1'b1;
            port_h_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            drive_q   <= 1'b0;
            cen_q     <= 1'b1;
            oen_q     <= 1'b1;
            wen_q     <= 1'b1;
            busy_q    <= 1'b0;
            l_ack_q   <= 1'b0;
            h_ack_q   <= 1'b0;
            l_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            port_h_q <= port_h_d;
            we_q     <= we_d;
            drive_q  <= drive_d;
            cen_q    <= cen_d;
            oen_q    <= oen_d;
            wen_q    <= wen_d;
            busy_q   <= busy_d;
            l_ack_q  <= l_ack_d;
            h_ack_q  <= h_ack_d;

            // Address and write data are captured once at grant; later
            // changes on the requester side do not disturb the access.
            if (grant) begin
                last_h_q <= grant_h;
                addr_q   <= grant_h ? h_bus.addr : l_bus.addr;
                wdata_q  <= grant_h ? h_bus.wdata : l_bus.wdata;
            end

            if (state_q == SETUP) begin
                cnt_q <= CNT_LOAD;
            end else if ((state_q == STROBE) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end

            // Sample the SRAM while oen is still low on the final strobe cycle.
            if (last_strobe && !we_q) begin
                if (port_h_q) begin
                    h_rdata_q <= sram_data;
                end else begin
                    l_rdata_q <= sram_data;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign sram_addr = addr_q;
    assign sram_cen  = cen_q;
    assign sram_oen  = oen_q;
    assign sram_wen  = wen_q;
    assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

    assign l_bus.ack   = l_ack_q;
    assign l_bus.rdata = l_rdata_q;
    assign h_bus.ack   = h_ack_q;
    assign h_bus.rdata = h_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Self-checking bench for sram_arbiter: one instance at the default strobe
// width and one at STROBE_CYC=1, each attached to a behavioural SRAM.
// Expected read data comes from a reference memory updated on write acks;
// expected timing comes from the strobe-width arithmetic of the access cycle.
module tb_sram_arbiter;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;
    localparam int SC     = 6;
    localparam int SC1    = 1;
    localparam int TMO    = 2 * (SC + 3) + 6;
    localparam int N_TX   = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit mon_on = 1'b0;

    logic [DATA_W-1:0] ref_mem [int];

    // Default-strobe instance.
    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) l_bus ();
    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) h_bus ();
    logic              busy;
    logic [ADDR_W-1:0] sram_addr;
    wire  [DATA_W-1:0] sram_data;
    logic              sram_cen, sram_oen, sram_wen;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STROBE_CYC(SC)) dut (
        .clk(clk), .rst(rst), .l_bus(l_bus), .h_bus(h_bus), .busy(busy),
        .sram_addr(sram_addr), .sram_data(sram_data), .sram_cen(sram_cen),
        .sram_oen(sram_oen), .sram_wen(sram_wen));

    assign sram_data = (!sram_cen && !sram_oen) ? mem[sram_addr] : {DATA_W{1'bz}};
    always @(posedge clk) if (!sram_cen && !sram_wen) mem[sram_addr] <= sram_data;

    // Single-cycle-strobe instance.
    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) l1_bus ();
    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) h1_bus ();
    logic              busy1;
    logic [ADDR_W-1:0] sram1_addr;
    wire  [DATA_W-1:0] sram1_data;
    logic              sram1_cen, sram1_oen, sram1_wen;
    logic [DATA_W-1:0] mem1 [0:(1<<ADDR_W)-1];

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STROBE_CYC(SC1)) dut_s1 (
        .clk(clk), .rst(rst), .l_bus(l1_bus), .h_bus(h1_bus), .busy(busy1),
        .sram_addr(sram1_addr), .sram_data(sram1_data), .sram_cen(sram1_cen),
        .sram_oen(sram1_oen), .sram_wen(sram1_wen));

    assign sram1_data = (!sram1_cen && !sram1_oen) ? mem1[sram1_addr] : {DATA_W{1'bz}};
    always @(posedge clk) if (!sram1_cen && !sram1_wen) mem1[sram1_addr] <= sram1_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return '0;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return ADDR_W'(((i & 8) != 0) ? (32'h1_0040 + (i & 7)) : (32'h40 + (i & 7)));
    endfunction

    task automatic drive(input bit hp, input bit rq, input bit we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (hp) begin
            h_bus.req = rq; h_bus.we = we; h_bus.addr = a; h_bus.wdata = d;
        end else begin
            l_bus.req = rq; l_bus.we = we; l_bus.addr = a; l_bus.wdata = d;
        end
    endtask

    // Pin-level protocol checks on every cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("wen_oen_excl", sram_wen | sram_oen, 1);
            chk("busy_vs_cen", busy, !sram_cen);
            chk("wen_oen_excl_s1", sram1_wen | sram1_oen, 1);
            chk("busy_vs_cen_s1", busy1, !sram1_cen);
        end
    end

    // Round-robin: a port still waiting when the other is acked is served next.
    bit rr_on = 1'b0, rr_valid = 1'b0, rr_prev_h = 1'b0, rr_other_wait = 1'b0;
    always @(negedge clk) begin
        if (rr_on && (l_bus.ack || h_bus.ack)) begin
            chk("ack_onehot", l_bus.ack & h_bus.ack, 0);
            if (rr_valid && rr_other_wait) chk("rr_alternate", h_bus.ack, !rr_prev_h);
            rr_prev_h     = h_bus.ack;
            rr_other_wait = h_bus.ack ? l_bus.req : h_bus.req;
            rr_valid      = 1'b1;
        end
    end

    // One uncontended access on the default instance, starting at a negedge
    // with the arbiter idle; checks strobe widths, ack timing, bus contents.
    task automatic single(input bit hp, input bit we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input string tag);
        int cen_lo = 0, wen_lo = 0, oen_lo = 0, ack_at = -1, stray = 0;
        bit addr_bad = 1'b0, data_bad = 1'b0;
        logic [DATA_W-1:0] rd = '0;
        logic [DATA_W-1:0] other_rd;
        logic [DATA_W-1:0] exp_rd;
        exp_rd   = ref_rd(a);
        other_rd = hp ? l_bus.rdata : h_bus.rdata;
        drive(hp, 1'b1, we, a, d);
        for (int k = 1; k <= SC + 5; k++) begin
            @(negedge clk);
            if (!sram_cen) begin
                cen_lo++;
                if (sram_addr !== a) addr_bad = 1'b1;
            end
            if (!sram_wen) begin
                wen_lo++;
                if (sram_data !== d) data_bad = 1'b1;
            end
            if (!sram_oen) oen_lo++;
            if (hp ? h_bus.ack : l_bus.ack) begin
                if (ack_at < 0) ack_at = k; else stray++;
                rd = hp ? h_bus.rdata : l_bus.rdata;
                drive(hp, 1'b0, we, a, d);
            end
            if (hp ? l_bus.ack : h_bus.ack) stray++;
        end
        chk({tag, "_cen_cycles"}, cen_lo, SC + 2);
        chk({tag, "_wen_cycles"}, wen_lo, we ? SC : 0);
        chk({tag, "_oen_cycles"}, oen_lo, we ? 0 : SC);
        chk({tag, "_ack_cycle"}, ack_at, SC + 2);
        chk({tag, "_addr_bad"}, addr_bad, 0);
        chk({tag, "_wdata_bad"}, data_bad, 0);
        chk({tag, "_stray_ack"}, stray, 0);
        chk({tag, "_other_rdata_hold"}, hp ? l_bus.rdata : h_bus.rdata, other_rd);
        if (we) ref_mem[int'(a)] = d;
        else    chk({tag, "_rdata"}, rd, exp_rd);
    endtask

    task automatic tie_test();
        int ack_k[$];
        bit ack_p[$];
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 1'b1, 17'h00010, 8'h11);
        drive(1, 1'b1, 1'b1, 17'h00020, 8'h22);
        for (int k = 1; k <= 4 * (SC + 3) - 1; k++) begin
            @(negedge clk);
            if (l_bus.ack) begin ack_k.push_back(k); ack_p.push_back(1'b0); end
            if (h_bus.ack) begin ack_k.push_back(k); ack_p.push_back(1'b1); end
            if (k == 4 * (SC + 3) - 1) begin
                drive(0, 1'b0, 1'b1, 17'h00010, 8'h11);
                drive(1, 1'b0, 1'b1, 17'h00020, 8'h22);
            end
        end
        chk("tie_ack_count", ack_k.size(), 4);
        for (int i = 0; i < 4 && i < ack_k.size(); i++) begin
            chk("tie_ack_cycle", ack_k[i], (SC + 2) + i * (SC + 3));
            chk("tie_ack_port", ack_p[i], i % 2);
        end
        ref_mem[32'h10] = 8'h11;
        ref_mem[32'h20] = 8'h22;
        repeat (3) @(negedge clk);
    endtask

    task automatic rst_mid_test();
        int acks = 0;
        drive(0, 1'b1, 1'b1, 17'h00100, 8'h77);
        repeat (4) @(negedge clk);
        chk("rst_pre_wen", sram_wen, 0);
        rst = 1'b1;
        drive(0, 1'b0, 1'b1, 17'h00100, 8'h77);
        @(negedge clk);
        chk("rst_cen", sram_cen, 1);
        chk("rst_oen", sram_oen, 1);
        chk("rst_wen", sram_wen, 1);
        chk("rst_busy", busy, 0);
        chk("rst_l_ack", l_bus.ack, 0);
        rst = 1'b0;
        repeat (SC + 4) begin
            @(negedge clk);
            if (l_bus.ack || h_bus.ack) acks++;
        end
        chk("rst_no_ack", acks, 0);
    endtask

    task automatic rand_port(input bit hp);
        for (int i = 0; i < N_TX; i++) begin
            bit we;
            bit got;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            we = 1'($urandom_range(0, 1));
            a  = addr_of(int'($urandom_range(0, 15)));
            d  = DATA_W'($urandom);
            drive(hp, 1'b1, we, a, d);
            got = 1'b0;
            for (int w = 0; w < TMO && !got; w++) begin
                @(negedge clk);
                if (hp ? h_bus.ack : l_bus.ack) got = 1'b1;
            end
            drive(hp, 1'b0, we, a, d);
            if (!got) begin
                chk(hp ? "rand_h_ack_timeout" : "rand_l_ack_timeout", 0, 1);
            end else if (we) begin
                ref_mem[int'(a)] = d;
            end else begin
                chk(hp ? "rand_h_rdata" : "rand_l_rdata",
                    hp ? h_bus.rdata : l_bus.rdata, ref_rd(a));
            end
        end
    endtask

    task automatic b2b_test();
        int ack_k[$];
        int idx = 0;
        l1_bus.req = 1'b1; l1_bus.we = 1'b1; l1_bus.addr = '0; l1_bus.wdata = 8'hC0;
        for (int k = 1; k <= 30 && idx < 4; k++) begin
            @(negedge clk);
            if (l1_bus.ack) begin
                ack_k.push_back(k);
                idx++;
                if (idx < 4) begin
                    l1_bus.addr  = ADDR_W'(idx);
                    l1_bus.wdata = DATA_W'(32'hC0 + idx);
                end else begin
                    l1_bus.req = 1'b0;
                end
            end
        end
        l1_bus.req = 1'b0;
        chk("b2b_ack_count", ack_k.size(), 4);
        if (ack_k.size() > 0) chk("b2b_first_ack", ack_k[0], SC1 + 2);
        for (int i = 1; i < ack_k.size(); i++) chk("b2b_ack_spacing", ack_k[i] - ack_k[i-1], SC1 + 3);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bit got = 1'b0;
            h1_bus.req = 1'b1; h1_bus.we = 1'b0; h1_bus.addr = ADDR_W'(i); h1_bus.wdata = '0;
            for (int w = 0; w < 12 && !got; w++) begin
                @(negedge clk);
                if (h1_bus.ack) got = 1'b1;
            end
            h1_bus.req = 1'b0;
            chk("b2b_read_ack", got, 1);
            chk("b2b_readback", h1_bus.rdata, DATA_W'(32'hC0 + i));
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        l1_bus.req = 1'b0; l1_bus.we = 1'b0; l1_bus.addr = '0; l1_bus.wdata = '0;
        h1_bus.req = 1'b0; h1_bus.we = 1'b0; h1_bus.addr = '0; h1_bus.wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_cen", sram_cen, 1);
        chk("reset_oen", sram_oen, 1);
        chk("reset_wen", sram_wen, 1);
        chk("reset_addr", sram_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_l_ack", l_bus.ack, 0);
        chk("reset_h_ack", h_bus.ack, 0);
        chk("reset_l_rdata", l_bus.rdata, 0);
        chk("reset_h_rdata", h_bus.rdata, 0);
        chk("reset_cen_s1", sram1_cen, 1);
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);

        single(0, 1'b1, 17'h1ABCD, 8'h5A, "l_write");
        single(1, 1'b0, 17'h1ABCD, 8'h00, "h_read");
        chk("h_read_value", h_bus.rdata, 8'h5A);

        tie_test();
        single(1, 1'b0, 17'h00010, 8'h00, "tie_rd_l");
        single(0, 1'b0, 17'h00020, 8'h00, "tie_rd_h");

        rst_mid_test();

        single(0, 1'b1, 17'h1FFFF, 8'hE1, "wrap_hi_wr");
        single(0, 1'b1, 17'h00000, 8'h1E, "wrap_lo_wr");
        single(1, 1'b0, 17'h1FFFF, 8'h00, "wrap_hi_rd");
        single(1, 1'b0, 17'h00000, 8'h00, "wrap_lo_rd");

        for (int i = 0; i < 16; i++) single(i[0], 1'b1, addr_of(i), DATA_W'(i * 29 + 3), "prewrite");

        rr_on = 1'b1;
        fork
            rand_port(1'b0);
            rand_port(1'b1);
        join
        rr_on = 1'b0;
        repeat (SC + 4) @(negedge clk);

        b2b_test();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
